pipeline_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Consumes decoded controls (branch/jump from the
//  ID-stage decoder, MemRead from ID/EX) and the data-memory handshake, and drives PC/IF-ID write enables, the
//  IF/ID flush, the ID/EX bubble select and a global freeze. Adds a start gate, memory-wait FSM with timeout,
//  and saturating stall/flush performance counters.

---
 rtl/pipeline_pkg.sv | 36 +++
 rtl/hazard_sat_counter.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the pipeline hazard controller: FSM state encoding
// and the bundle of pipeline control enables driven each cycle.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } hz_state_e;

  localparam int REG_AW_DEF      = 5;
  localparam int CNT_W_DEF       = 16;
  localparam int MEM_TIMEOUT_DEF = 64;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic freeze;
  } hz_ctrl_t;

  // Pipeline held with zero controls entering ID/EX (IDLE and FAULT).
  localparam hz_ctrl_t CTRL_IDLE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                     idex_bubble: 1'b1, freeze: 1'b1};
  localparam hz_ctrl_t CTRL_MEM_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                          idex_bubble: 1'b0, freeze: 1'b1};
  localparam hz_ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                         idex_bubble: 1'b1, freeze: 1'b0};
  localparam hz_ctrl_t CTRL_REDIRECT = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                         idex_bubble: 1'b0, freeze: 1'b0};
  localparam hz_ctrl_t CTRL_FLOW = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                     idex_bubble: 1'b0, freeze: 1'b0};

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter: one increment per qualifying cycle, holds at all-ones,
// cleared by the synchronous reset.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;

  assign w_sat = (r_cnt == {CNT_W{1'b1}});

  // Count register with saturation at the maximum value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (inc_i && !w_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: start gate, load-use and branch
// hazards, data-memory wait with timeout fault, and stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              branch_i,
  input  logic              branch_taken_i,
  input  logic              jump_i,
  input  logic              idex_memread_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              freeze_o,
  output logic              fault_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e         r_state;
  hz_state_e         w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_next_wait;
  logic              r_fault;
  hz_ctrl_t          w_ctrl;
  hz_ctrl_t          w_run_ctrl;
  logic              w_load_use;
  logic              w_redirect;
  logic              w_active;
  logic              w_stall_inc;
  logic              w_flush_inc;

  // r0 is never a real load destination, so it can never create a load-use hazard.
  function automatic logic f_load_use(input logic              memread,
                                      input logic [REG_AW-1:0] ld_rt,
                                      input logic [REG_AW-1:0] use_rs,
                                      input logic [REG_AW-1:0] use_rt);
    return memread && (ld_rt != {REG_AW{1'b0}}) && ((ld_rt == use_rs) || (ld_rt == use_rt));
  endfunction

  assign w_load_use = f_load_use(idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i);
  assign w_redirect = jump_i || (branch_i && branch_taken_i);

  // Normal-flow hazard priority: load-use bubble masks any redirect, which retries next cycle.
  always_comb begin
    w_run_ctrl = CTRL_FLOW;
    if (w_load_use) begin
      w_run_ctrl = CTRL_LOAD_USE;
    end else if (w_redirect) begin
      w_run_ctrl = CTRL_REDIRECT;
    end else begin
      w_run_ctrl = CTRL_FLOW;
    end
  end

  // Next-state, wait counter and control outputs.
  always_comb begin
    w_next_state = r_state;
    w_next_wait  = r_wait_cnt;
    w_ctrl       = CTRL_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          w_ctrl       = CTRL_MEM_STALL;
          w_next_state = ST_MEM_WAIT;
          w_next_wait  = WAIT_W'(1);
        end else begin
          w_ctrl       = w_run_ctrl;
          w_next_state = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack_i) begin
          w_ctrl       = w_run_ctrl;
          w_next_state = ST_RUN;
          w_next_wait  = {WAIT_W{1'b0}};
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_ctrl       = CTRL_MEM_STALL;
          w_next_state = ST_FAULT;
          w_next_wait  = {WAIT_W{1'b0}};
        end else begin
          w_ctrl       = CTRL_MEM_STALL;
          w_next_state = ST_MEM_WAIT;
          w_next_wait  = r_wait_cnt + WAIT_W'(1);
        end
      end
      ST_FAULT: begin
        w_ctrl       = CTRL_IDLE;
        w_next_state = ST_FAULT;
      end
      default: begin
        w_ctrl       = CTRL_IDLE;
        w_next_state = ST_IDLE;
        w_next_wait  = {WAIT_W{1'b0}};
      end
    endcase
  end

  // State, wait counter and sticky fault registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= {WAIT_W{1'b0}};
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait;
      r_fault    <= r_fault || (w_next_state == ST_FAULT);
    end
  end

  assign w_active    = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);
  assign w_stall_inc = w_active && !w_ctrl.pc_write;
  assign w_flush_inc = w_active && w_ctrl.ifid_flush;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stall_inc),
    .cnt_o (stall_cnt_o)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_flush_inc),
    .cnt_o (flush_cnt_o)
  );

  assign pc_write_o    = w_ctrl.pc_write;
  assign ifid_write_o  = w_ctrl.ifid_write;
  assign ifid_flush_o  = w_ctrl.ifid_flush;
  assign idex_bubble_o = w_ctrl.idex_bubble;
  assign freeze_o      = w_ctrl.freeze;
  assign fault_o       = r_fault;

endmodule
